// File: rtl/timer_irq_pkg.sv
// Shared definitions for the timer_irq block: register map, CTRL fields, modes, FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package timer_irq_pkg;

  // Word offsets on the 2-bit register address.
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  // CTRL bit positions.
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

  // MODE encodings; the two unused codes fall back to one-shot behaviour.
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

endpackage

// File: rtl/timer_irq.sv
// Programmable down-counter with one-shot / auto-reload modes and a maskable interrupt.
// Latency: EN write at edge t0 -> LOAD after t0+1, COUNT=PRESET after t0+2, pending after t0+3+PRESET.
// Backpressure: none; register writes always complete in one cycle, reads are combinational.
//
// Ports:
//   clk    - system clock, all state changes on rising edge
//   reset  - asynchronous active-low reset
//   addr   - register select (0 CTRL, 1 PRESET, 2 COUNT, 3 reserved)
//   we     - write strobe, sampled at the clock edge
//   wdata  - write data
//   rdata  - combinational read data, zero-extended; reserved reads 0
//   irq    - registered interrupt request (pending AND IM)
module timer_irq
  import timer_irq_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  state_t               state_q, state_d;
  logic                 en_q, en_d;
  logic [1:0]           mode_q, mode_d;
  logic                 im_q, im_d;
  logic [COUNT_W-1:0]   preset_q, preset_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 pending_q, pending_d;
  logic                 ctrl_wr;
  logic                 preset_wr;

  assign ctrl_wr   = we && (addr == ADDR_CTRL);
  assign preset_wr = we && (addr == ADDR_PRESET);

  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    mode_d    = mode_q;
    im_d      = im_q;
    preset_d  = preset_q;
    count_d   = count_q;
    pending_d = pending_q;

    // The FSM acts on the CTRL value held before this edge, so a CTRL
    // write only changes counting behaviour from the following edge on.
    case (state_q)
      ST_IDLE: begin
        if (en_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en_q) begin
          state_d = ST_IDLE;
        end else if (count_q == '0) begin
          // Zero is detected before decrementing, so the counter never wraps.
          state_d   = ST_INT;
          pending_d = 1'b1;
        end else begin
          count_d = count_q - COUNT_W'(1);
        end
      end
      ST_INT: begin
        if (mode_q == MODE_RELOAD) begin
          pending_d = 1'b0;
        end else begin
          en_d = 1'b0;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A CTRL write overrides whatever the FSM did to EN/MODE/IM/pending
    // on the same edge: software acknowledge always wins.
    if (ctrl_wr) begin
      en_d      = wdata[CTRL_EN_BIT];
      mode_d    = wdata[CTRL_MODE_MSB:CTRL_MODE_LSB];
      im_d      = wdata[CTRL_IM_BIT];
      pending_d = 1'b0;
    end

    // PRESET is only consumed in LOAD, so a mid-count write affects the next period.
    if (preset_wr) begin
      preset_d = wdata[COUNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      en_q      <= 1'b0;
      mode_q    <= MODE_ONESHOT;
      im_q      <= 1'b0;
      preset_q  <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
      irq       <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      mode_q    <= mode_d;
      im_q      <= im_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      // Built from next-state values so irq lines up with pending in the same cycle.
      irq       <= pending_d & im_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_CTRL: begin
        rdata[CTRL_EN_BIT]                 = en_q;
        rdata[CTRL_MODE_MSB:CTRL_MODE_LSB] = mode_q;
        rdata[CTRL_IM_BIT]                 = im_q;
      end
      ADDR_PRESET: rdata = 32'(preset_q);
      ADDR_COUNT:  rdata = 32'(count_q);
      default:     rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_irq.sv
module tb_timer_irq;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int total = 0;
  int bad   = 0;

  timer_irq #(.COUNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every step ends 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The write lands on the next rising edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we    = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  // Reference model: k = number of edges since the edge that wrote CTRL with EN=1.
  // Pending first appears after edge 3+P; auto-reload repeats every P+4 edges.
  function automatic logic exp_irq(input int k, input int p, input logic rl, input logic im);
    if (!im || k < 3 + p) return 1'b0;
    if (!rl) return 1'b1;
    return ((k - 3 - p) % (p + 4)) == 0;
  endfunction

  // COUNT equals P at edge 2, falls by one per edge to 0, then rests at 0
  // until the next reload (auto-reload) or forever (one-shot). Valid for k >= 2.
  function automatic int exp_count(input int k, input int p, input logic rl);
    int j;
    j = rl ? (k - 2) % (p + 4) : (k - 2);
    return (j <= p) ? (p - j) : 0;
  endfunction

  // One-shot clears EN on the edge after pending is set.
  function automatic logic exp_en(input int k, input int p, input logic rl);
    return rl ? 1'b1 : (k < 4 + p);
  endfunction

  initial begin
    logic [31:0] r;
    int          p;
    logic [1:0]  mode;
    logic        im;
    logic        rl;
    int          hi;
    int          edges[$];

    reset = 1'b0;
    addr  = 2'd0;
    we    = 1'b0;
    wdata = 32'd0;
    #12;

    // ---------------- reset state ----------------
    check("rst_irq", 32'(irq), 32'd0);
    rd(2'd0, r); check("rst_ctrl", r, 32'd0);
    rd(2'd3, r); check("rst_reserved", r, 32'd0);
    do_reset();

    // ---------------- reset mid-count ----------------
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 5; k++) tick();
    rd(2'd2, r); check("midcnt_count_before", r, 32'd7);
    reset = 1'b0;
    #1;
    rd(2'd2, r); check("midcnt_count_rst", r, 32'd0);
    check("midcnt_irq_rst", 32'(irq), 32'd0);
    rd(2'd0, r); check("midcnt_ctrl_rst", r, 32'd0);
    rd(2'd1, r); check("midcnt_preset_rst", r, 32'd0);
    tick();
    reset = 1'b1;
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (irq) hi++;
    end
    check("midcnt_no_irq_after", 32'(hi), 32'd0);
    rd(2'd0, r); check("midcnt_ctrl_idle", r, 32'd0);

    // ---------------- directed one-shot ----------------
    do_reset();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 7; k++) tick();
    check("os_irq_edge7", 32'(irq), 32'd0);
    tick();
    check("os_irq_edge8", 32'(irq), 32'd1);
    repeat (4) tick();
    check("os_irq_held", 32'(irq), 32'd1);
    rd(2'd0, r); check("os_ctrl_en_cleared", r, 32'h8);
    wr(2'd0, 32'h8);
    check("os_irq_ack", 32'(irq), 32'd0);

    // ---------------- directed auto-reload ----------------
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    edges.delete();
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (irq) edges.push_back(k);
    end
    check("ar_pulse_count", 32'(edges.size()), 32'd4);
    if (edges.size() == 4) begin
      check("ar_first_pulse", 32'(edges[0]), 32'd5);
      for (int i = 1; i < 4; i++) check("ar_period", 32'(edges[i] - edges[i-1]), 32'd6);
    end

    // ---------------- mask ----------------
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h1);
    hi = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (irq) hi++;
    end
    check("mask_no_irq", 32'(hi), 32'd0);
    rd(2'd0, r); check("mask_ctrl_after_oneshot", r, 32'd0);
    wr(2'd0, 32'h8);
    hi = 0;
    for (int k = 0; k < 5; k++) begin
      if (irq) hi++;
      tick();
    end
    check("mask_ack_no_irq", 32'(hi), 32'd0);

    // ---------------- stop mid-count ----------------
    do_reset();
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 5; k++) tick();
    wr(2'd0, 32'h8);
    hi = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (irq) hi++;
    end
    rd(2'd2, r); check("stop_count_frozen", r, 32'd6);
    check("stop_no_irq", 32'(hi), 32'd0);

    // ---------------- PRESET written mid-period ----------------
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 3; k++) tick();
    wr(2'd1, 32'd1);
    edges.delete();
    for (int k = 5; k <= 20; k++) begin
      tick();
      if (irq) edges.push_back(k);
    end
    check("preset_pulse_count", 32'(edges.size()), 32'd3);
    if (edges.size() == 3) begin
      check("preset_cur_period", 32'(edges[0]), 32'd6);
      check("preset_next_period", 32'(edges[1] - edges[0]), 32'd5);
      check("preset_next_period2", 32'(edges[2] - edges[1]), 32'd5);
    end

    // ---------------- collision: CTRL write on pending-set edge ----------------
    do_reset();
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    tick();
    tick();
    wr(2'd0, 32'h8);
    check("coll_irq_edge", 32'(irq), 32'd0);
    hi = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (irq) hi++;
    end
    check("coll_no_irq", 32'(hi), 32'd0);
    rd(2'd0, r); check("coll_ctrl", r, 32'h8);

    // ---------------- PRESET=0 alone ----------------
    do_reset();
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    tick();
    tick();
    check("p0_irq_edge2", 32'(irq), 32'd0);
    tick();
    check("p0_irq_edge3", 32'(irq), 32'd1);

    // ---------------- randomized runs against the model ----------------
    for (int it = 0; it < 12; it++) begin
      p    = int'($urandom_range(0, 9));
      mode = 2'($urandom_range(0, 3));
      im   = 1'($urandom_range(0, 1));
      rl   = (mode == 2'b01);
      do_reset();
      wr(2'd1, 32'(p));
      wr(2'd0, {28'd0, im, mode, 1'b1});
      for (int k = 1; k <= 3 * (p + 4) + 2; k++) begin
        tick();
        check($sformatf("rnd%0d_irq_k%0d", it, k), 32'(irq), 32'(exp_irq(k, p, rl, im)));
        if (k >= 2) begin
          rd(2'd2, r);
          check($sformatf("rnd%0d_count_k%0d", it, k), r, 32'(exp_count(k, p, rl)));
        end
        rd(2'd0, r);
        check($sformatf("rnd%0d_ctrl_k%0d", it, k), r,
              {28'd0, im, mode, exp_en(k, p, rl)});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
